// File: rtl/synthesijer_div_arb_pkg.sv
// Shared types and helpers for the divider arbiter and its divider.
// Imported by every file of the shared-divider slice.
package synthesijer_div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 32;
  localparam int DIV_LATENCY = DEF_WIDTH + 2;

  function automatic int div_latency(input int w);
    return w + 2;
  endfunction

  function automatic logic [15:0] onehot(
    input logic [3:0] idx,
    input int         n
  );
    logic [15:0] r;
    r = '0;
    if (int'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/synthesijer_div.sv
// Iterative signed divider: restoring on magnitudes, then
// sign fix-up; one-cycle valid pulse per nd.
module synthesijer_div
  import synthesijer_div_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             nd,
  output logic [WIDTH-1:0] quantient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int STEPS = div_latency(WIDTH) - 2;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [WIDTH-1:0] quo_q, rmo_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, qneg_q, rneg_q, vld_q;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] rem_n, dvd_n;
  logic [WIDTH-1:0] abs_a, abs_b;

  // One restoring step: shift in next dividend bit, try subtract.
  always_comb begin
    t     = {rem_q, dvd_q[WIDTH-1]};
    ge    = (t >= {1'b0, dvs_q});
    rem_n = ge ? WIDTH'(t - {1'b0, dvs_q})
               : t[WIDTH-1:0];
    dvd_n = {dvd_q[WIDTH-2:0], ge};
    abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  // Load on nd, iterate STEPS times, then publish for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      rmo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (nd) begin
        dvd_q  <= abs_a;
        dvs_q  <= abs_b;
        rem_q  <= '0;
        cnt_q  <= CW'(STEPS);
        run_q  <= 1'b1;
        qneg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        rneg_q <= a[WIDTH-1];
      end else if (run_q) begin
        if (cnt_q != '0) begin
          dvd_q <= dvd_n;
          rem_q <= rem_n;
          cnt_q <= cnt_q - 1'b1;
        end else begin
          run_q <= 1'b0;
          vld_q <= 1'b1;
          quo_q <= qneg_q ? (~dvd_q + 1'b1) : dvd_q;
          rmo_q <= rneg_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
    end
  end

  assign quantient = quo_q;
  assign remainder = rmo_q;
  assign valid     = vld_q;

endmodule

// File: rtl/synthesijer_rr_pick.sv
// Combinational round-robin picker: first requester at or
// above rr_ptr, wrapping; reusable for any shared operator.
module synthesijer_rr_pick #(
  parameter int NPORTS = 4,
  parameter int IDX_W  = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  // Scan from the farthest offset down so the nearest wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (req[idx[IDX_W-1:0]]) begin
        grant = idx[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synthesijer_div_arbiter.sv
// Round-robin share of one signed divider among NPORTS
// requesters; result held until the next completion.
module synthesijer_div_arbiter
  import synthesijer_div_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 4,
  parameter int IDX_W  = $clog2(NPORTS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS*WIDTH-1:0] a_flat,
  input  logic [NPORTS*WIDTH-1:0] b_flat,
  output logic [NPORTS-1:0]       done,
  output logic [WIDTH-1:0]        quotient,
  output logic [WIDTH-1:0]        remainder,
  output logic                    div0,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              pend_q, pend_d;
  logic [NPORTS-1:0] done_q, done_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              div0_q, div0_d;

  logic [NPORTS-1:0] eff_req;
  logic [IDX_W-1:0]  pick_grant;
  logic              pick_valid;
  logic [WIDTH-1:0]  op_a, op_b, sel_b;
  logic              nd;
  logic [WIDTH-1:0]  div_q, div_r;
  logic              div_valid;

  // A port is never re-granted in its own done cycle.
  assign eff_req = req & ~done_q;

  synthesijer_rr_pick #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (eff_req),
    .rr_ptr (rr_q),
    .grant  (pick_grant),
    .valid  (pick_valid)
  );

  // Operand mux for the owner and divisor peek for the pick.
  always_comb begin
    op_a  = '0;
    op_b  = '0;
    sel_b = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        op_a = a_flat[i*WIDTH +: WIDTH];
        op_b = b_flat[i*WIDTH +: WIDTH];
      end
      if (pick_grant == IDX_W'(i))
        sel_b = b_flat[i*WIDTH +: WIDTH];
    end
  end

  assign nd = (state_q == ISSUE);

  synthesijer_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (~reset_n),
    .a         (op_a),
    .b         (op_b),
    .nd        (nd),
    .quantient (div_q),
    .remainder (div_r),
    .valid     (div_valid)
  );

  // Grant, issue one nd pulse, capture on the valid edge.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    pend_d  = pend_q;
    done_d  = '0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          pend_d  = (sel_b == '0);
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_valid) begin
          quot_d  = div_q;
          rem_d   = div_r;
          div0_d  = pend_q;
          done_d  = NPORTS'(onehot(4'(grant_q), NPORTS));
          rr_d    = (grant_q == IDX_W'(NPORTS - 1))
                    ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight divide.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div0      = div0_q;
  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_synthesijer_div_arbiter.sv
// Scoreboard bench for the shared divider arbiter.
// Stimulus pushes expectations; a monitor checks each done.
module tb_synthesijer_div_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] a_flat, b_flat;
  logic [N-1:0]  done;
  logic [W-1:0]  quotient, remainder;
  logic          div0, busy;
  logic [IW-1:0] grant_idx;

  synthesijer_div_arbiter #(
    .WIDTH  (W),
    .NPORTS (N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
    logic         chk_qr;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d",
               name, got, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the queue head.
  always @(negedge clk) begin
    if (done != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got=%b expected none", done);
      end else begin
        e = sb.pop_front();
        chk("done_mask", 32'(done), 32'(e.mask));
        chk("div0", 32'(div0), 32'(e.d0));
        if (e.chk_qr) begin
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
        end
        if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    req = req & ~done;
  endtask

  task automatic issue(input int p, input int a, input int b,
                       input int q, input int r, input bit d0,
                       input bit cq, input int lat);
    exp_t x;
    logic [N-1:0] m;
    m = '0;
    m[p] = 1'b1;
    a_flat[p*W +: W] = a;
    b_flat[p*W +: W] = b;
    req[p] = 1'b1;
    x.mask = m;
    x.q = q;
    x.r = r;
    x.d0 = d0;
    x.chk_qr = cq;
    x.cyc = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(x);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    tick();
    while (!(req == '0 && !busy && done == '0) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL idle_timeout got=busy expected=idle");
    end
  endtask

  task automatic wait_done(input int p);
    int n;
    n = 0;
    tick();
    while (!done[p] && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL done_timeout port=%0d got=none expected=done", p);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
    chk({tag, "_div0"}, 32'(div0), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // All four at once: served 0,1,2,3, 36 cycles apart.
    issue(0, 50, 5, 10, 0, 0, 1, 36);
    issue(1, -37, 4, -9, -1, 0, 1, 72);
    issue(2, 1000, -33, -30, 10, 0, 1, 108);
    issue(3, 7, 9, 0, 7, 0, 1, 144);
    wait_idle();

    issue(1, 100, 7, 14, 2, 0, 1, 36);
    wait_idle();

    issue(0, -100, 7, -14, -2, 0, 1, 36);
    wait_idle();
    issue(0, 100, -7, -14, 2, 0, 1, 36);
    wait_idle();
    issue(0, -100, -7, 14, -2, 0, 1, 36);
    wait_idle();

    // Divide by zero flags div0; the next normal divide clears it.
    issue(3, 5, 0, 0, 0, 1, 0, 36);
    wait_idle();
    issue(3, 9, 3, 3, 0, 0, 1, 36);
    wait_idle();

    // Ports 0 and 2 re-request right away: 0,2,0,2.
    issue(0, 20, 3, 6, 2, 0, 1, 36);
    issue(2, -20, 3, -6, -2, 0, 1, 72);
    wait_done(0);
    issue(0, 21, -4, -5, 1, 0, 1, 72);
    wait_done(2);
    issue(2, 1, 1, 1, 0, 0, 1, 72);
    wait_idle();

    // Reset in WAIT cycle 10: no done for the aborted divide.
    a_flat[1*W +: W] = 50;
    b_flat[1*W +: W] = 5;
    req[1] = 1'b1;
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk_zero("midreset");
    reset_n = 1'b1;
    repeat (40) tick();
    issue(2, -100, -7, 14, -2, 0, 1, 36);
    wait_idle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
